// File: rtl/window_generator.sv
// Streaming K x K sliding-window generator: buffers K-1 image rows plus a K-pixel
// tap window and emits a full K x K x CHANNELS window at the configured stride.
module window_generator #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 1,
  parameter int IMG_WIDTH   = 5,
  parameter int IMG_HEIGHT  = 5,
  parameter int STRIDE      = 1
) (
  input  logic                                                 clock,
  input  logic                                                 sreset,
  input  logic                                                 data_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                       data_in,
  output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_WIDTH-1:0] window_out,
  output logic                                                 window_valid,
  output logic                                                 frame_done,
  output logic [$clog2(IMG_HEIGHT)-1:0]                        row_idx,
  output logic [$clog2(IMG_WIDTH)-1:0]                         col_idx
);

  localparam int K         = KERNEL_SIZE;
  localparam int PIX_W     = CHANNELS * DATA_WIDTH;
  localparam int WIN_W     = K * K * PIX_W;
  localparam int ROW_W     = $clog2(IMG_HEIGHT);
  localparam int COL_W     = $clog2(IMG_WIDTH);
  localparam int PH_W      = $clog2(STRIDE) + 1;
  // Delay line spanning K-1 full rows plus K-1 pixels; with the live input it
  // exposes every pixel of the window ending at the current position.
  localparam int CHAIN_LEN = (K - 1) * IMG_WIDTH + K - 1;

  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(STRIDE - 1);

  logic [PIX_W-1:0] chain [CHAIN_LEN];
  logic [PIX_W-1:0] tap   [CHAIN_LEN+1];
  logic [WIN_W-1:0] window_next;
  logic [PH_W-1:0]  row_ph;
  logic [PH_W-1:0]  col_ph;
  logic             row_ok;
  logic             col_ok;
  logic             last_col;
  logic             last_row;
  logic             accept;

  // Pixel storage is not reset: the row/column gates keep stale taps out of any
  // emitted window.
  always_ff @(posedge clock) begin
    if (accept) begin
      chain[0] <= data_in;
      for (int i = 1; i < CHAIN_LEN; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  always_comb begin
    tap[0] = data_in;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      tap[i+1] = chain[i];
    end
  end

  always_comb begin
    window_next = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        window_next[(r*K+c)*PIX_W +: PIX_W] = tap[(K-1-r)*IMG_WIDTH + (K-1-c)];
      end
    end
  end

  assign accept   = data_valid && !sreset;
  assign row_ok   = (row_idx >= ROW_FIRST) && (row_ph == '0);
  assign col_ok   = (col_idx >= COL_FIRST) && (col_ph == '0);
  assign last_col = (col_idx == COL_LAST);
  assign last_row = (row_idx == ROW_LAST);

  // Stage boundary: accepted pixel -> registered window / pulses / counters
  always_ff @(posedge clock) begin
    if (sreset) begin
      window_out   <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      row_idx      <= '0;
      col_idx      <= '0;
      row_ph       <= '0;
      col_ph       <= '0;
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (data_valid) begin
        window_valid <= row_ok && col_ok;
        frame_done   <= last_row && last_col;
        if (row_ok && col_ok) begin
          window_out <= window_next;
        end
        if (last_col) begin
          col_idx <= '0;
          col_ph  <= '0;
          if (last_row) begin
            row_idx <= '0;
            row_ph  <= '0;
          end else begin
            row_idx <= row_idx + ROW_W'(1);
            // Phase stays 0 until the first full window row, then cycles mod STRIDE.
            if (row_idx < ROW_FIRST || row_ph == PH_LAST) begin
              row_ph <= '0;
            end else begin
              row_ph <= row_ph + PH_W'(1);
            end
          end
        end else begin
          col_idx <= col_idx + COL_W'(1);
          if (col_idx < COL_FIRST || col_ph == PH_LAST) begin
            col_ph <= '0;
          end else begin
            col_ph <= col_ph + PH_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_window_generator.sv
// Bench for window_generator: three instances (stride 1, stride 2, two channels)
// share one pixel stream and are compared every cycle against a frame-array model.
module tb_window_generator;

  localparam int K  = 3;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic sreset = 1'b1;
  logic data_valid = 1'b0;
  logic [DW-1:0]   din1 = '0;
  logic [2*DW-1:0] din2 = '0;

  logic [K*K*DW-1:0]   wo1, wo2;
  logic [K*K*2*DW-1:0] woc;
  logic wv1, wv2, wvc, fd1, fd2, fdc;
  logic [2:0] ri1, ri2, ric, ci1, ci2, cic;

  always #5 clk = ~clk;

  window_generator #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .CHANNELS(1), .IMG_WIDTH(W),
                     .IMG_HEIGHT(H), .STRIDE(1)) dut_s1 (
    .clock(clk), .sreset(sreset), .data_valid(data_valid), .data_in(din1),
    .window_out(wo1), .window_valid(wv1), .frame_done(fd1), .row_idx(ri1), .col_idx(ci1));

  window_generator #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .CHANNELS(1), .IMG_WIDTH(W),
                     .IMG_HEIGHT(H), .STRIDE(2)) dut_s2 (
    .clock(clk), .sreset(sreset), .data_valid(data_valid), .data_in(din1),
    .window_out(wo2), .window_valid(wv2), .frame_done(fd2), .row_idx(ri2), .col_idx(ci2));

  window_generator #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .CHANNELS(2), .IMG_WIDTH(W),
                     .IMG_HEIGHT(H), .STRIDE(1)) dut_c2 (
    .clock(clk), .sreset(sreset), .data_valid(data_valid), .data_in(din2),
    .window_out(woc), .window_valid(wvc), .frame_done(fdc), .row_idx(ric), .col_idx(cic));

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the current frame as a 2-D array indexed by pixel position.
  logic [DW-1:0] frm [H][W];
  int n = 0;
  logic ev1, ev2, efd;
  logic [K*K*DW-1:0]   ew1, ew2;
  logic [K*K*2*DW-1:0] ewc;

  int cnt1, cnt2, cntc, cntfd;
  logic [K*K*DW-1:0]   first1, last1, last2, tenth1;
  logic [K*K*2*DW-1:0] firstc;

  function automatic logic [K*K*DW-1:0] build1(input int r, input int c);
    logic [K*K*DW-1:0] w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*DW +: DW] = frm[r-K+1+i][c-K+1+j];
    return w;
  endfunction

  function automatic logic [K*K*2*DW-1:0] build2(input int r, input int c);
    logic [K*K*2*DW-1:0] w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        w[((i*K+j)*2+0)*DW +: DW] = frm[r-K+1+i][c-K+1+j];
        w[((i*K+j)*2+1)*DW +: DW] = frm[r-K+1+i][c-K+1+j] + 8'd128;
      end
    return w;
  endfunction

  // Window whose top-left pixel carries value base in a ramp image (base + 5*row + col).
  function automatic logic [K*K*DW-1:0] ramp_win(input int base);
    logic [K*K*DW-1:0] w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*DW +: DW] = DW'(base + i*W + j);
    return w;
  endfunction

  task automatic clear_counts();
    cnt1 = 0; cnt2 = 0; cntc = 0; cntfd = 0;
  endtask

  task automatic step(input bit v, input bit rst, input logic [DW-1:0] pix);
    int r, c;
    @(negedge clk);
    sreset     = rst;
    data_valid = v;
    din1       = pix;
    din2       = {pix + 8'd128, pix};
    ev1 = 1'b0; ev2 = 1'b0; efd = 1'b0;
    if (rst) begin
      n = 0; ew1 = '0; ew2 = '0; ewc = '0;
    end else if (v) begin
      r = n / W;
      c = n % W;
      frm[r][c] = pix;
      if (r >= K-1 && c >= K-1) begin
        ev1 = 1'b1;
        ew1 = build1(r, c);
        ewc = build2(r, c);
        if ((r-K+1) % 2 == 0 && (c-K+1) % 2 == 0) begin
          ev2 = 1'b1;
          ew2 = build1(r, c);
        end
      end
      efd = (n == W*H-1);
      n = (n + 1) % (W*H);
    end
    @(posedge clk);
    #1;
    check("s1_vld", wv1, ev1);
    check("s1_fd",  fd1, efd);
    check("s1_row", ri1, n / W);
    check("s1_col", ci1, n % W);
    check("s1_win", wo1, ew1);
    check("s2_vld", wv2, ev2);
    check("s2_fd",  fd2, efd);
    check("s2_row", ri2, n / W);
    check("s2_col", ci2, n % W);
    check("s2_win", wo2, ew2);
    check("c2_vld", wvc, ev1);
    check("c2_fd",  fdc, efd);
    check("c2_row", ric, n / W);
    check("c2_col", cic, n % W);
    check("c2_win", woc, ewc);
    if (wv1 === 1'b1) begin
      if (cnt1 == 0) first1 = wo1;
      if (cnt1 == 9) tenth1 = wo1;
      last1 = wo1;
      cnt1++;
    end
    if (wv2 === 1'b1) begin
      last2 = wo2;
      cnt2++;
    end
    if (wvc === 1'b1) begin
      if (cntc == 0) firstc = woc;
      cntc++;
    end
    if (fd1 === 1'b1) cntfd++;
  endtask

  task automatic feed_frame(input int base, input bit bubbles);
    for (int p = 0; p < W*H; p++) begin
      if (bubbles) step(1'b0, 1'b0, 8'($urandom));
      step(1'b1, 1'b0, 8'(base + p));
    end
  endtask

  initial begin
    step(1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b1, 8'd55);

    // Single frame 0..24, back-to-back
    clear_counts();
    feed_frame(0, 1'b0);
    check("a_cnt_s1", cnt1, 9);
    check("a_cnt_s2", cnt2, 4);
    check("a_cnt_fd", cntfd, 1);
    check("a_first_s1", first1, ramp_win(0));
    check("a_last_s1", last1, ramp_win(12));
    check("a_last_s2", last2, ramp_win(12));
    check("a_c2_lane111", firstc[((1*K+1)*2+1)*DW +: DW], 134);
    check("a_c2_lane000", firstc[0 +: DW], 0);

    // Same frame with a bubble before every pixel
    clear_counts();
    feed_frame(0, 1'b1);
    check("b_cnt_s1", cnt1, 9);
    check("b_first_s1", first1, ramp_win(0));

    // Two frames back-to-back
    clear_counts();
    feed_frame(0, 1'b0);
    feed_frame(100, 1'b0);
    check("c_cnt_s1", cnt1, 18);
    check("c_cnt_fd", cntfd, 2);
    check("c_f2_first", tenth1, ramp_win(100));

    // Reset coinciding with pixel 17, then a full frame
    for (int p = 0; p < 17; p++) step(1'b1, 1'b0, 8'(p));
    step(1'b1, 1'b1, 8'd17);
    clear_counts();
    feed_frame(0, 1'b0);
    check("d_cnt_s1", cnt1, 9);
    check("d_cnt_s2", cnt2, 4);
    check("d_last_s1", last1, ramp_win(12));

    // Random pixels, bubbles and occasional resets
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(3) != 0), ($urandom_range(149) == 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
